// File: rtl/regfile_wr_arbiter_if.sv
// Writeback request bus and registered regfile write-port bundle
// for the register file write arbiter.
interface regfile_wr_arbiter_if #(
  parameter int NUM_REQ        = 6,
  parameter int NUM_PORT       = 2,
  parameter int REG_ADDR_WIDTH = 6,
  parameter int REG_DATA_WIDTH = 64
);
  logic [NUM_REQ-1:0]                 req_valid;
  logic [NUM_REQ-1:0]                 req_ready;
  logic [NUM_REQ*REG_ADDR_WIDTH-1:0]  req_addr;
  logic [NUM_REQ*REG_DATA_WIDTH-1:0]  req_data;
  logic [NUM_PORT-1:0]                wr_valid;
  logic [NUM_PORT*REG_ADDR_WIDTH-1:0] wr_addr;
  logic [NUM_PORT*REG_DATA_WIDTH-1:0] wr_data;
  logic                               busy;

  modport master (
    output req_valid, req_addr, req_data,
    input  req_ready, wr_valid, wr_addr, wr_data, busy
  );

  modport slave (
    input  req_valid, req_addr, req_data,
    output req_ready, wr_valid, wr_addr, wr_data, busy
  );
endinterface

// File: rtl/regfile_wr_arbiter.sv
// Round-robin regfile write-port arbiter: one buffered slot per channel,
// up to NUM_PORT same-cycle writes, equal addresses serialised.
module regfile_wr_arbiter #(
  parameter int NUM_REQ        = 6,
  parameter int NUM_PORT       = 2,
  parameter int REG_ADDR_WIDTH = 6,
  parameter int REG_DATA_WIDTH = 64,
  parameter bit DROP_ZERO      = 1'b1
) (
  input logic                 clk,
  input logic                 rstn,
  regfile_wr_arbiter_if.slave bus
);
  localparam int AW = REG_ADDR_WIDTH;
  localparam int DW = REG_DATA_WIDTH;
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]     r_slot_v;
  logic [AW-1:0]          r_slot_addr [NUM_REQ];
  logic [DW-1:0]          r_slot_data [NUM_REQ];
  logic [PW-1:0]          r_rr_ptr;
  logic [NUM_PORT-1:0]    r_wr_valid;
  logic [NUM_PORT*AW-1:0] r_wr_addr;
  logic [NUM_PORT*DW-1:0] r_wr_data;

  logic [NUM_REQ-1:0]  w_grant;
  logic [NUM_REQ-1:0]  w_ready;
  logic [NUM_REQ-1:0]  w_load;
  logic [NUM_PORT-1:0] w_pv;
  logic [PW-1:0]       w_pch [NUM_PORT];
  logic [PW-1:0]       w_rr_nxt;

  // Scan from rr_ptr; k-th accepted slot goes to port k.
  always_comb begin : grant_scan
    int            n;
    logic [PW-1:0] c;
    logic          hit;
    n        = 0;
    c        = '0;
    hit      = 1'b0;
    w_grant  = '0;
    w_pv     = '0;
    w_rr_nxt = r_rr_ptr;
    for (int k = 0; k < NUM_PORT; k++) begin
      w_pch[k] = '0;
    end
    for (int j = 0; j < NUM_REQ; j++) begin
      c   = PW'((int'(r_rr_ptr) + j) % NUM_REQ);
      hit = 1'b0;
      for (int k = 0; k < NUM_PORT; k++) begin
        if (w_pv[k] && r_slot_addr[w_pch[k]] == r_slot_addr[c]) begin
          hit = 1'b1;
        end
      end
      if (r_slot_v[c] && n < NUM_PORT && !hit) begin
        for (int k = 0; k < NUM_PORT; k++) begin
          if (k == n) begin
            w_pv[k]  = 1'b1;
            w_pch[k] = c;
          end
        end
        w_grant[c] = 1'b1;
        w_rr_nxt   = PW'((int'(c) + 1) % NUM_REQ);
        n          = n + 1;
      end
    end
  end

  assign w_ready = ~r_slot_v | w_grant;

  // Address-0 writes complete the handshake but never occupy a slot.
  always_comb begin
    w_load = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_load[i] = bus.req_valid[i] & w_ready[i] &
                  ~(DROP_ZERO && bus.req_addr[i*AW +: AW] == '0);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_slot_v   <= '0;
      r_rr_ptr   <= '0;
      r_wr_valid <= '0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        r_slot_addr[i] <= '0;
        r_slot_data[i] <= '0;
      end
    end else begin
      r_slot_v   <= (r_slot_v & ~w_grant) | w_load;
      r_rr_ptr   <= w_rr_nxt;
      r_wr_valid <= w_pv;
      for (int k = 0; k < NUM_PORT; k++) begin
        if (w_pv[k]) begin
          r_wr_addr[k*AW +: AW] <= r_slot_addr[w_pch[k]];
          r_wr_data[k*DW +: DW] <= r_slot_data[w_pch[k]];
        end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (w_load[i]) begin
          r_slot_addr[i] <= bus.req_addr[i*AW +: AW];
          r_slot_data[i] <= bus.req_data[i*DW +: DW];
        end
      end
    end
  end

  assign bus.req_ready = w_ready;
  assign bus.wr_valid  = r_wr_valid;
  assign bus.wr_addr   = r_wr_addr;
  assign bus.wr_data   = r_wr_data;
  assign bus.busy      = (|r_slot_v) | (|r_wr_valid);
endmodule
